// File: rtl/mod_mul_iter_54.sv
// Iterative modular multiplier: output_data = (a*b) mod q, one bit of b per clock
// via MSB-first interleaved shift-add with a conditional subtract after each step.
module mod_mul_iter_54 #(
  parameter int DATA_WIDTH = 54
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] modulus,
  input  logic [DATA_WIDTH-1:0] input_data0,
  input  logic [DATA_WIDTH-1:0] input_data1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  busy
);

  // state  | meaning
  // S_IDLE | waiting for an operand set, in_ready high
  // S_RUN  | one bit of b consumed per clock, cnt = bit index
  // S_DONE | result presented, waiting for out_ready

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    q_r;
  logic [W-1:0]    acc;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    result_r;
  logic            idle_r;
  logic            out_valid_r;
  logic            busy_r;

  logic [W:0]      q_ext;
  logic [W:0]      t_dbl;
  logic [W:0]      t_red;
  logic [W:0]      t_add;
  logic [W:0]      t_sum;
  logic [W-1:0]    step_next;

  // Intermediates are W+1 bits wide: with acc, a < q the worst case is 2q-2,
  // so a single conditional subtract after each of doubling and adding keeps
  // the partial result below q.
  always_comb begin
    q_ext = {1'b0, q_r};
    t_dbl = {acc, 1'b0};
    t_red = (t_dbl >= q_ext) ? (t_dbl - q_ext) : t_dbl;
    t_add = t_red + {1'b0, a_r};
    t_sum = t_red;
    if (b_r[cnt]) begin
      t_sum = (t_add >= q_ext) ? (t_add - q_ext) : t_add;
    end
    step_next = W'(t_sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      q_r         <= '0;
      acc         <= '0;
      cnt         <= '0;
      result_r    <= '0;
      idle_r      <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r    <= input_data0;
            b_r    <= input_data1;
            q_r    <= modulus;
            acc    <= '0;
            cnt    <= CW'(W - 1);
            state  <= S_RUN;
            idle_r <= 1'b0;
            busy_r <= 1'b1;
          end
        end
        S_RUN: begin
          acc <= step_next;
          if (cnt == '0) begin
            result_r    <= step_next;
            state       <= S_DONE;
            out_valid_r <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state       <= S_IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            idle_r      <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          idle_r      <= 1'b1;
        end
      endcase
    end
  end

  // Gated by rst so in_ready is low throughout reset and high right after release.
  assign in_ready    = idle_r & rst;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign output_data = result_r;

endmodule

// File: tb/tb_mod_mul_iter_54.sv
// Scoreboard bench for mod_mul_iter_54: driver queues hand-computed results,
// a negedge monitor checks each output handshake and the result latency.
module tb_mod_mul_iter_54;
  localparam int W = 54;

  localparam logic [W-1:0] Q54   = 54'h3F_FFFF_FFFF_FFDF;  // 2^54-33
  localparam logic [W-1:0] P53   = 54'h20_0000_0000_0000;  // 2^53
  localparam logic [W-1:0] ALL1  = 54'h3F_FFFF_FFFF_FFFF;  // 2^54-1

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] modulus;
  logic [W-1:0] input_data0;
  logic [W-1:0] input_data1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] output_data;
  logic         busy;

  mod_mul_iter_54 #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .modulus     (modulus),
    .input_data0 (input_data0),
    .input_data1 (input_data1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .output_data (output_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int prev_hs = 0;
  bit chk_interval = 1'b0;
  logic ov_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from DUT updates and driver changes.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && !ov_prev) check("latency", 64'(cyc - hs_cyc), 64'(W));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'(output_data), 64'hDEAD);
        else check("result", 64'(output_data), 64'(exp_q.pop_front()));
      end
    end
    ov_prev = out_valid & rst;
  end

  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input bit scramble);
    int t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      return;
    end
    modulus     = q;
    input_data0 = a;
    input_data1 = b;
    in_valid    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    hs_cyc = cyc;
    if (chk_interval) check("issue_interval", 64'(hs_cyc - prev_hs), 64'(W + 2));
    prev_hs  = hs_cyc;
    in_valid = 1'b0;
    if (scramble) begin
      repeat (W - 1) begin
        modulus     = W'({$urandom, $urandom});
        input_data0 = W'({$urandom, $urandom});
        input_data1 = W'({$urandom, $urandom});
        in_valid    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    modulus = '0; input_data0 = '0; input_data1 = '0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_output_data", 64'(output_data), 64'd0);
    rst = 1'b1;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // 3*5 mod 7
    issue(54'd7, 54'd3, 54'd5, 54'd1, 1'b0);
    check("run_busy", 64'(busy), 64'd1);
    check("run_in_ready", 64'(in_ready), 64'd0);
    chk_interval = 1'b1;
    issue(Q54, Q54 - 54'd1, Q54 - 54'd1, 54'd1, 1'b0);
    issue(Q54, P53, 54'd2, 54'd33, 1'b0);
    issue(54'd97, 54'd0, 54'd96, 54'd0, 1'b0);
    issue(54'd97, 54'd96, 54'd1, 54'd96, 1'b0);
    issue(ALL1, ALL1 - 54'd1, 54'd2, ALL1 - 54'd2, 1'b0);
    issue(54'd2, 54'd1, 54'd1, 54'd1, 1'b0);
    issue(54'd1000, 54'd999, 54'd999, 54'd1, 1'b0);
    // 50*60 = 3000 = 29*101 + 71, operands scrambled while running
    issue(54'd101, 54'd50, 54'd60, 54'd71, 1'b1);
    wait_drain();
    chk_interval = 1'b0;

    // Backpressure: 5*7 = 35 = 2*13 + 9
    out_ready = 1'b0;
    issue(54'd13, 54'd5, 54'd7, 54'd9, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
    end
    check("bp_reached_done", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_output_data", 64'(output_data), 64'd9);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid    = i[0];
      modulus     = 54'd11;
      input_data0 = 54'd3;
      input_data1 = 54'd4;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_out_valid", 64'(out_valid), 64'd0);
    check("bp_after_in_ready", 64'(in_ready), 64'd1);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check("bp_single_transfer", 64'(out_valid), 64'd0);

    // Reset in the middle of RUN abandons the operation
    issue(54'd97, 54'd96, 54'd1, 54'd96, 1'b0);
    repeat (19) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("mrst_in_ready", 64'(in_ready), 64'd0);
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_output_data", 64'(output_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_release_in_ready", 64'(in_ready), 64'd1);
    // 12*12 = 144 = 11*13 + 1
    issue(54'd13, 54'd12, 54'd12, 54'd1, 1'b0);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mod_mul_iter_54.md
MOD_MUL_ITER_54 -- requirements
Module: mod_mul_iter_54

Interface
REQ-001 Parameter: DATA_WIDTH, default 54, operand/modulus/result width W.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset: asynchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/modulus valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 modulus  input  W  modulus q; sampled only on input handshake.
REQ-007 input_data0  input  W  multiplicand a; sampled only on input handshake.
REQ-008 input_data1  input  W  multiplier b; sampled only on input handshake.
REQ-009 out_valid  output  1  output_data holds a finished result.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 output_data  output  W  (a*b) mod q.
REQ-012 busy  output  1  high in RUN or DONE.

Function
REQ-013 Computes (a*b) mod q by MSB-first interleaved shift-add; one bit of b per clock, no hardware multiplier.
REQ-014 Preconditions: 2 <= q <= 2^W-1, a < q, b < q. Out-of-range inputs give an undefined result, but timing and handshake stay unchanged.
REQ-015 States: IDLE, RUN, DONE; exactly one active.
REQ-016 IDLE: in_ready=1, out_valid=0. Input handshake (in_valid & in_ready) latches a, b, q, clears acc, loads bit counter cnt=W-1, and moves to RUN.
REQ-017 RUN: each cycle, t = 2*acc, then t -= q if t >= q; if b[cnt]=1, t += a, then t -= q if t >= q; acc <= t; cnt decrements.
REQ-018 Every intermediate value is held in W+1 bits (max 2q-2 < 2^(W+1)); one conditional subtract per step is sufficient and mandatory.
REQ-019 RUN with cnt=0: the final step result is written to output_data and the state moves to DONE.
REQ-020 Latency: handshake at edge k; out_valid rises after edge k+W (exactly W RUN cycles).
REQ-021 DONE: out_valid=1 and output_data held stable until out_ready=1. out_valid & out_ready returns the state to IDLE at that edge.
REQ-022 DONE: in_ready=0; no input accepted until IDLE. Minimum issue interval is W+2 cycles.
REQ-023 in_ready=0 in RUN and DONE. in_valid is ignored in those states and the latched operands stay unchanged.
REQ-024 Input changes on modulus/input_data0/input_data1 after the handshake have no effect on the result in flight.
REQ-025 b=0 or a=0: the block still runs the full W cycles and the result is 0.
REQ-026 out_ready held high continuously: result handshake completes on the first DONE cycle; IDLE follows on the next cycle.

Reset
REQ-027 Reset values: state=IDLE, in_ready=1 once rst deasserted, out_valid=0, busy=0, output_data=0, acc=0, cnt=0.
REQ-028 Reset asserted in RUN or DONE abandons the operation immediately. No result is emitted afterward, and the in-flight value is lost.
REQ-029 in_ready is 0 while rst=0.

Verification
REQ-030 q=7, a=3, b=5, out_ready=1 -> output_data=1, out_valid rises exactly 54 cycles after handshake, then IDLE.
REQ-031 q=2^54-33, a=b=q-1 -> output_data=1. Also a=2^53, b=2 with q=2^54-33 -> output_data=33.
REQ-032 q=97, a=0, b=96 -> output_data=0 after full 54 cycles. Also a=96, b=1 -> 96.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and output_data stable, in_ready=0, in_valid pulses ignored. On out_ready=1 -> single transfer, then IDLE.
REQ-034 Operand change: input_data0/input_data1/modulus randomized every cycle during RUN -> result equals the product of the latched operands mod the latched q.
REQ-035 Reset pulse at RUN cycle 20 -> outputs at reset values. A new operation (q=13, a=12, b=12) then gives 1 with normal latency.
